fifo_wr_arbiter: RTL and testbench

//   Round-robin write arbiter sharing one fifo write port between N_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ producers.
// A grant is locked for a burst, ending on src_last, the beat cap or an idle timeout.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int TMO       = 16,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BCW = $clog2(MAX_BURST + 1),
    localparam int TCW = $clog2(TMO + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    src_valid,
    input  logic [N_REQ*DW-1:0] src_data,
    input  logic [N_REQ-1:0]    src_last,
    output logic [N_REQ-1:0]    src_ready,
    output logic [DW-1:0]       fifo_din,
    output logic                fifo_writep,
    input  logic                fifo_fullp,
    output logic [IDW-1:0]      grant_id,
    output logic                busy
);

    // state | meaning
    // IDLE  | no grant held; pick the next requester at or after rr_ptr
    // BUSY  | grant held by grant_id; beats forwarded to the fifo
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic               pick_vld;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     rr_next;
    logic [DW-1:0]      g_data;
    logic               g_valid;
    logic               g_last;
    logic               beat;
    logic               burst_end;
    logic               tmo_end;
    logic               release_grant;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (src_valid[IDW'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh_q[i]) begin
                g_data = src_data[i*DW +: DW];
            end
        end
    end

    assign g_valid   = |(src_valid & grant_oh_q);
    assign g_last    = |(src_last & grant_oh_q);
    assign beat      = (state_q == BUSY) & g_valid & ~fifo_fullp;
    assign burst_end = (burst_cnt_q == BCW'(MAX_BURST - 1));
    assign tmo_end   = (tmo_cnt_q == TCW'(TMO - 1));
    assign rr_next   = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // Back-pressure freezes both counters; only a genuinely absent beat counts as idle.
    assign release_grant = (beat & (g_last | burst_end))
                         | ((state_q == BUSY) & tmo_end & ~g_valid & ~fifo_fullp);

    always_comb begin
        state_d     = state_q;
        grant_oh_d  = grant_oh_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = BUSY;
                    grant_id_d  = pick_id;
                    grant_oh_d  = N_REQ'(1) << pick_id;
                    burst_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    state_d     = IDLE;
                    grant_oh_d  = '0;
                    rr_ptr_d    = rr_next;
                    burst_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    tmo_cnt_d   = '0;
                end else if (~g_valid & ~fifo_fullp) begin
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_oh_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_oh_q  <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign fifo_writep = beat;
    assign fifo_din    = g_data;
    assign src_ready   = grant_oh_q & {N_REQ{beat}};
    assign grant_id    = grant_id_q;
    assign busy        = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked
// against a per-cycle behavioural model of grants, bursts, timeouts and fifo order.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int MB  = 8;
    localparam int TMO = 16;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_last = '0;
    logic [N-1:0]    src_ready;
    logic [DW-1:0]   fifo_din;
    logic            fifo_writep;
    logic            fifo_fullp = 1'b0;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .fifo_din(fifo_din), .fifo_writep(fifo_writep),
        .fifo_fullp(fifo_fullp), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // pending beats per producer
    logic [DW-1:0] pq_data [N][$];
    bit            pq_last [N][$];

    // model state
    bit m_busy = 1'b0;
    int m_g = 0, m_ptr = 0, m_beats = 0, m_idle = 0;

    // observations of the DUT
    logic [31:0] dut_grants[$], dut_words[$], dut_bursts[$], dut_idles[$];
    int cur_len = 0, cur_idle = 0;
    bit prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int p, input logic [DW-1:0] d, input bit last);
        pq_data[p].push_back(d);
        pq_last[p].push_back(last);
    endtask

    task automatic clear_obs();
        dut_grants.delete(); dut_words.delete(); dut_bursts.delete(); dut_idles.delete();
    endtask

    function automatic bit pending(input logic [N-1:0] en);
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (en[i] && pq_data[i].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic present(input logic [N-1:0] en, input int pct);
        for (int i = 0; i < N; i++) begin
            if (en[i] && pq_data[i].size() > 0 && int'($urandom_range(99)) < pct) begin
                src_valid[i]          = 1'b1;
                src_data[i*DW +: DW]  = pq_data[i][0];
                src_last[i]           = pq_last[i][0];
            end else begin
                src_valid[i]          = 1'b0;
                src_data[i*DW +: DW]  = DW'($urandom);
                src_last[i]           = 1'($urandom_range(1));
            end
        end
    endtask

    // One clock: compare at negedge, advance the model, return at posedge+1.
    task automatic step();
        bit           e_beat, found, lastf;
        logic [N-1:0] e_ready;
        @(negedge clk);
        e_beat  = m_busy && src_valid[m_g] && !fifo_fullp;
        e_ready = '0;
        if (e_beat) e_ready[m_g] = 1'b1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("fifo_writep", 32'(fifo_writep), 32'(e_beat));
        chk("src_ready", 32'(src_ready), 32'(e_ready));
        if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_g));
        if (e_beat) chk("fifo_din", 32'(fifo_din), 32'(pq_data[m_g][0]));

        if (prev_busy && !busy) begin
            dut_bursts.push_back(32'(cur_len));
            dut_idles.push_back(32'(cur_idle));
        end
        if (busy && !prev_busy) begin
            dut_grants.push_back(32'(grant_id));
            cur_len = 0; cur_idle = 0;
        end
        if (fifo_writep) begin
            dut_words.push_back(32'(fifo_din));
            cur_len++; cur_idle = 0;
        end else if (busy) begin
            cur_idle++;
        end
        prev_busy = busy;

        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (!found && src_valid[idx]) begin
                    found = 1'b1;
                    m_g   = idx;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_beats = 0; m_idle = 0;
            end
        end else if (e_beat) begin
            lastf = pq_last[m_g][0];
            void'(pq_data[m_g].pop_front());
            void'(pq_last[m_g].pop_front());
            m_beats++; m_idle = 0;
            if (lastf || m_beats == MB) begin
                m_busy = 1'b0; m_ptr = (m_g + 1) % N;
            end
        end else if (!src_valid[m_g] && !fifo_fullp) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_busy = 1'b0; m_ptr = (m_g + 1) % N;
            end
        end
        @(posedge clk); #1;
    endtask

    // Runs until the enabled producers drain and the grant is released; fifo_fullp is
    // forced high for cycles in [win_lo, win_hi) and otherwise random at full_pct.
    task automatic run(input logic [N-1:0] en, input int pct, input int full_pct,
                       input int max_cyc, input int win_lo, input int win_hi);
        int cyc = 0;
        while ((pending(en) || m_busy) && cyc < max_cyc) begin
            fifo_fullp = (cyc >= win_lo && cyc < win_hi) || (int'($urandom_range(99)) < full_pct);
            present(en, pct);
            step();
            cyc++;
        end
        chk("drain_bound", 32'(cyc >= max_cyc), 32'd0);
        fifo_fullp = 1'b0;
        present('0, 100);
        step();
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ptr = 0; m_beats = 0; m_idle = 0;
        prev_busy = 1'b0; cur_len = 0; cur_idle = 0;
    endtask

    logic [31:0] exp_q[$];

    initial begin
        // 1: reset with every producer requesting
        for (int i = 0; i < N; i++) load(i, DW'(16'h00A0 + i), 1'b1);
        present('1, 100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_writep", 32'(fifo_writep), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        run('1, 100, 0, 200, -1, -1);
        chk("t1_first_grant", dut_grants.size() > 0 ? dut_grants[0] : 32'hFFFF_FFFF, 32'd0);

        // 2: round robin, single-beat bursts
        clear_obs();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) load(i, DW'(((i + 1) << 12) + k), 1'b1);
        run('1, 100, 0, 200, -1, -1);
        exp_q = '{0, 1, 2, 3, 0};
        foreach (exp_q[k])
            chk("t2_grant", k < dut_grants.size() ? dut_grants[k] : 32'hFFFF_FFFF, exp_q[k]);
        exp_q = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h1001};
        foreach (exp_q[k])
            chk("t2_word", k < dut_words.size() ? dut_words[k] : 32'hFFFF_FFFF, exp_q[k]);

        // 3: burst cap then timeout
        clear_obs();
        for (int k = 0; k < 20; k++) load(2, DW'(16'h0201 + k), 1'b0);
        run(4'b0100, 100, 0, 300, -1, -1);
        exp_q = '{8, 8, 4};
        chk("t3_nbursts", 32'(dut_bursts.size()), 32'd3);
        foreach (exp_q[k])
            chk("t3_burst", k < dut_bursts.size() ? dut_bursts[k] : 32'hFFFF_FFFF, exp_q[k]);
        for (int k = 0; k < 20; k++)
            chk("t3_word", k < dut_words.size() ? dut_words[k] : 32'hFFFF_FFFF, 32'(16'h0201 + k));

        // 4: back-pressure for 5 cycles mid-burst; 7 beats must stay one burst
        clear_obs();
        for (int k = 0; k < 7; k++) load(1, DW'(16'h0101 + k), k == 6);
        run(4'b0010, 100, 0, 200, 4, 9);
        chk("t4_nbursts", 32'(dut_bursts.size()), 32'd1);
        chk("t4_burst", dut_bursts.size() > 0 ? dut_bursts[0] : 32'hFFFF_FFFF, 32'd7);
        chk("t4_nwords", 32'(dut_words.size()), 32'd7);

        // 5: timeout after two beats, then producer 0 wins over producer 3
        clear_obs();
        load(3, 16'h0301, 1'b0);
        load(3, 16'h0302, 1'b0);
        run(4'b1000, 100, 0, 200, -1, -1);
        chk("t5_burst", dut_bursts.size() > 0 ? dut_bursts[0] : 32'hFFFF_FFFF, 32'd2);
        chk("t5_idle", dut_idles.size() > 0 ? dut_idles[0] : 32'hFFFF_FFFF, 32'd16);
        clear_obs();
        load(0, 16'h0001, 1'b1);
        load(3, 16'h0303, 1'b1);
        run(4'b1001, 100, 0, 200, -1, -1);
        chk("t5_next_grant", dut_grants.size() > 0 ? dut_grants[0] : 32'hFFFF_FFFF, 32'd0);

        // 6: async reset between edges in the middle of a burst
        clear_obs();
        for (int k = 0; k < 6; k++) load(0, DW'(16'h0A01 + k), k == 5);
        for (int c = 0; c < 3; c++) begin
            present(4'b0001, 100);
            step();
        end
        present(4'b0001, 100);
        #2 rstn = 1'b0;
        #1;
        chk("t6_writep", 32'(fifo_writep), 32'd0);
        chk("t6_ready", 32'(src_ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        run(4'b0001, 100, 0, 200, -1, -1);
        chk("t6_nwords", 32'(dut_words.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("t6_word", k < dut_words.size() ? dut_words[k] : 32'hFFFF_FFFF, 32'(16'h0A01 + k));

        // random traffic with random back-pressure and gaps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                int nb = int'($urandom_range(12));
                for (int k = 0; k < nb; k++) load(i, DW'($urandom), $urandom_range(3) == 0);
            end
            run('1, 70, 20, 4000, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
